i2c_line_conditioner: RTL

// - Conditions raw SDA/SCL pad inputs for the I2C master's bit-phase FSM (k_data* states).
// - Synchronises the pad inputs, rejects glitches and emits SCL edge strobes and START/STOP strobes.
// - Tracks bus-busy state.
// - Sits directly upstream of the RX sampling logic: its SDA output is the SDA that the data states shift into rx_reg.

---
 rtl/i2c_line_conditioner_if.sv | 31 +++
 rtl/i2c_line_conditioner.sv | 124 ++++++++++++
 2 files changed

// File: rtl/i2c_line_conditioner_if.sv
// Signal bundle for the I2C line conditioner.
// master: the conditioner itself (takes raw pads, drives conditioned levels and strobes).
// slave : the consumer side (drives raw pads, observes conditioned outputs).
//   sda_in, scl_in        raw pad levels, asynchronous to clk
//   sda, scl              filtered line levels
//   scl_rise, scl_fall    1-cycle filtered SCL edge strobes
//   start_det, stop_det   1-cycle START / STOP strobes
//   bus_busy              high between START and STOP (or timeout)
//   timeout               1-cycle bus timeout strobe
interface i2c_line_conditioner_if;
  logic sda_in;
  logic scl_in;
  logic sda;
  logic scl;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic bus_busy;
  logic timeout;

  modport master (
    input  sda_in, scl_in,
    output sda, scl, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout
  );

  modport slave (
    output sda_in, scl_in,
    input  sda, scl, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout
  );
endinterface

// File: rtl/i2c_line_conditioner.sv
// I2C pad conditioner: synchronises raw SDA/SCL, glitch-filters each line, and produces
// SCL edge strobes, START/STOP strobes and a bus-busy flag for the master's bit-phase FSM.
// The filtered SDA is the level the data states shift into rx_reg.
// Optional feature (macro I2C_BUS_TIMEOUT_EN): SCL held low while busy for TIMEOUT_CYCLES
// cycles pulses timeout and returns the bus to idle. Without it, timeout is tied 0.
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    i2c_line_conditioner_if.master (pads in, conditioned levels/strobes out)
module i2c_line_conditioner #(
  parameter int unsigned SYNC_STAGES    = 2,  // >= 2
  parameter int unsigned FILTER_LEN     = 4   // 1..255
`ifdef I2C_BUS_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
`endif
) (
  input logic                          clk,
  input logic                          rst_n,
  i2c_line_conditioner_if.master       bus
);

  localparam logic [7:0] FiltLast = 8'(FILTER_LEN - 1);

  typedef enum logic [0:0] {StIdle, StActive} bus_state_e;

  // Line index 0 = SDA, 1 = SCL.
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [7:0]             cnt_q  [2];
  logic [1:0]             filt_q;
  logic [1:0]             pad;
  logic [1:0]             synced;
  logic [1:0]             upd;
  logic                   rise_q, fall_q, start_q, stop_q;
  logic                   tmo_evt;
  bus_state_e             state_q;

  assign pad = {bus.scl_in, bus.sda_in};

  // upd marks the cycle in which a filtered line takes its new level.
  always_comb begin
    synced = '0;
    upd    = '0;
    for (int i = 0; i < 2; i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
      upd[i]    = (synced[i] != filt_q[i]) && (cnt_q[i] == FiltLast);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= '1;
        cnt_q[i]  <= '0;
      end
      filt_q  <= 2'b11;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      state_q <= StIdle;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pad[i]};
        if (synced[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (upd[i]) begin
          filt_q[i] <= synced[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end

      rise_q  <= upd[1] & ~filt_q[1];
      fall_q  <= upd[1] &  filt_q[1];
      // SDA edge with SCL high and stable; a simultaneous SCL change disqualifies it.
      start_q <= upd[0] &  filt_q[0] & filt_q[1] & ~upd[1];
      stop_q  <= upd[0] & ~filt_q[0] & filt_q[1] & ~upd[1];

      unique case (state_q)
        StIdle:   if (start_q) state_q <= StActive;
        StActive: if (!start_q && (stop_q || tmo_evt)) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

`ifdef I2C_BUS_TIMEOUT_EN
  logic [15:0] tmo_ctr_q;
  logic        tmo_q;

  // Counts busy cycles with SCL low; the terminal count clears it, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_ctr_q <= '0;
      tmo_q     <= 1'b0;
    end else if ((state_q != StActive) || filt_q[1]) begin
      tmo_ctr_q <= '0;
      tmo_q     <= 1'b0;
    end else if (tmo_ctr_q == 16'(TIMEOUT_CYCLES - 1)) begin
      tmo_ctr_q <= '0;
      tmo_q     <= 1'b1;
    end else begin
      tmo_ctr_q <= tmo_ctr_q + 16'd1;
      tmo_q     <= 1'b0;
    end
  end

  assign tmo_evt = tmo_q;
`else
  assign tmo_evt = 1'b0;
`endif

  assign bus.sda       = filt_q[0];
  assign bus.scl       = filt_q[1];
  assign bus.scl_rise  = rise_q;
  assign bus.scl_fall  = fall_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.bus_busy  = (state_q == StActive);
  assign bus.timeout   = tmo_evt;

endmodule
